pool_window_gather: RTL and testbench

POOL_WINDOW_GATHER -- requirements
Module: pool_window_gather

---
 rtl/pool_pkg.sv | 11 +
 rtl/pool_line_buffer.sv | 30 +++
 rtl/pool_window_gather.sv | 110 +++++++++++
 tb/tb_pool_window_gather.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/pool_pkg.sv
// Shared constants and types for the window-gather and pooling blocks.
package pool_pkg;
  localparam int DW           = 9;
  localparam int WIN          = 4;
  localparam int WIN_ELEMS    = 16;
  localparam int POOL_LATENCY = 4;

  typedef logic [DW-1:0]                 pix_t;
  typedef logic [WIN-1:0][DW-1:0]        row4_t;
  typedef logic [WIN_ELEMS-1:0][DW-1:0]  win_t;
endpackage

// File: rtl/pool_line_buffer.sv
// One feature-map row store: single write port, 4-wide combinational read.
module pool_line_buffer
  import pool_pkg::*;
#(
  parameter int IMG_W = 28,
  localparam int AW   = $clog2(IMG_W)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  pix_t          wdata,
  input  logic [AW-1:0] rbase,
  output row4_t         rdata
);

  // Contents are not reset; every location is rewritten before it is read.
  pix_t mem [IMG_W];

  // Pixel write.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Four consecutive columns starting at the window's left edge.
  always_comb begin
    rdata = '0;
    for (int c = 0; c < WIN; c++) rdata[c] = mem[rbase + AW'(c)];
  end

endmodule

// File: rtl/pool_window_gather.sv
// Gathers non-overlapping 4x4 windows from a raster pixel stream.
module pool_window_gather
  import pool_pkg::*;
#(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic                    in_sof,
  input  logic [DW-1:0]           in_data,
  output logic [WIN_ELEMS*DW-1:0] feature_out,
  output logic                    window_valid,
  output logic                    pool_valid,
  output logic                    frame_done
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  logic [CW-1:0]                 col_q, col_c, rd_base;
  logic [RW-1:0]                 row_q, row_c;
  logic                          last_col, last_row, trig;
  logic [WIN-2:0]                lb_we;
  logic [WIN-2:0][WIN-1:0][DW-1:0] lb_rd;
  logic [WIN-2:0][DW-1:0]        sr;      // sr[0] newest row-3 pixel
  win_t                          win, feat_q;
  logic [POOL_LATENCY:0]         vld_pipe;

  // Start-of-frame forces the current pixel to (0,0), dropping any partial frame.
  assign col_c    = in_sof ? '0 : col_q;
  assign row_c    = in_sof ? '0 : row_q;
  assign last_col = (col_c == CW'(IMG_W - 1));
  assign last_row = (row_c == RW'(IMG_H - 1));
  assign rd_base  = col_c & ~CW'(3);
  assign trig     = in_valid && (row_c[1:0] == 2'd3) && (col_c[1:0] == 2'd3);

  // Raster position counters, advancing only on accepted pixels.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
    end else if (in_valid) begin
      if (last_col) begin
        col_q <= '0;
        row_q <= last_row ? '0 : row_c + RW'(1);
      end else begin
        col_q <= col_c + CW'(1);
        row_q <= row_c;
      end
    end
  end

  // Band rows 0..2 go to their own line store.
  always_comb begin
    lb_we = '0;
    for (int r = 0; r < WIN - 1; r++)
      lb_we[r] = in_valid && (row_c[1:0] == 2'(r));
  end

  for (genvar r = 0; r < WIN - 1; r++) begin : g_lb
    pool_line_buffer #(.IMG_W(IMG_W)) u_lb (
      .clk   (clk),
      .we    (lb_we[r]),
      .waddr (col_c),
      .wdata (in_data),
      .rbase (rd_base),
      .rdata (lb_rd[r])
    );
  end

  // Band row 3 only needs the last three pixels; the fourth is in_data itself.
  always_ff @(posedge clk) begin
    if (in_valid && (row_c[1:0] == 2'd3)) sr <= {sr[WIN-3:0], in_data};
  end

  // Assemble the window from the line stores, the shift register and in_data.
  always_comb begin
    win = '0;
    for (int r = 0; r < WIN - 1; r++)
      for (int c = 0; c < WIN; c++)
        win[r*WIN + c] = lb_rd[r][c];
    for (int c = 0; c < WIN - 1; c++)
      win[(WIN-1)*WIN + c] = sr[WIN-2-c];
    win[WIN_ELEMS-1] = in_data;
  end

  // Window register (held between windows) and frame-end pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      feat_q     <= '0;
      frame_done <= 1'b0;
    end else begin
      if (trig) feat_q <= win;
      frame_done <= in_valid && last_col && last_row;
    end
  end

  // Valid shift register: stage 0 is window_valid, last stage aligns with the pooler.
  always_ff @(posedge clk) begin
    if (!rst_n) vld_pipe <= '0;
    else        vld_pipe <= {vld_pipe[POOL_LATENCY-1:0], trig};
  end

  assign feature_out  = feat_q;
  assign window_valid = vld_pipe[0];
  assign pool_valid   = vld_pipe[POOL_LATENCY];

endmodule

// File: tb/tb_pool_window_gather.sv
// Randomized bench for pool_window_gather against an image-array reference model.
module tb_pool_window_gather;
  localparam int W = 8;
  localparam int H = 8;
  localparam int N = W * H;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_sof = 1'b0;
  logic [8:0]   in_data = '0;
  logic [143:0] feature_out;
  logic         window_valid, pool_valid, frame_done;

  pool_window_gather #(.IMG_W(W), .IMG_H(H)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_sof       (in_sof),
    .in_data      (in_data),
    .feature_out  (feature_out),
    .window_valid (window_valid),
    .pool_valid   (pool_valid),
    .frame_done   (frame_done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state: whole current frame as a 2-D image.
  logic [8:0]   img [H][W];
  int           m_idx = 0;
  logic [143:0] exp_feat = '0;
  bit   [4:0]   hist = '0;

  // Observed-output bookkeeping.
  int           wv_cnt = 0;
  int           fd_cnt = 0;
  logic [143:0] wins_q [$];

  task automatic chk(input string tag, input logic [143:0] got, input logic [143:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock: drive inputs, advance the model, check every output after the edge.
  task automatic step(input bit rst, input bit v, input bit sof, input logic [8:0] d);
    bit trig, fd;
    int r, c;
    rst_n = !rst; in_valid = v; in_sof = sof; in_data = d;
    trig = 0; fd = 0;
    if (rst) begin
      m_idx = 0; exp_feat = '0; hist = '0;
    end else if (v) begin
      if (sof) m_idx = 0;
      r = m_idx / W; c = m_idx % W;
      img[r][c] = d;
      if ((r % 4 == 3) && (c % 4 == 3)) begin
        trig = 1;
        for (int rr = 0; rr < 4; rr++)
          for (int cc = 0; cc < 4; cc++)
            exp_feat[(rr*4+cc)*9 +: 9] = img[r-3+rr][c-3+cc];
      end
      if (m_idx == N - 1) begin fd = 1; m_idx = 0; end
      else m_idx++;
    end
    hist = {hist[3:0], trig};
    @(posedge clk); #1;
    chk("window_valid", {143'b0, window_valid}, {143'b0, trig});
    chk("pool_valid",   {143'b0, pool_valid},   {143'b0, hist[4]});
    chk("frame_done",   {143'b0, frame_done},   {143'b0, fd});
    chk("feature_out",  feature_out, exp_feat);
    if (window_valid === 1'b1) begin wv_cnt++; wins_q.push_back(feature_out); end
    if (frame_done === 1'b1) fd_cnt++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 9'($urandom));
  endtask

  // gap < 0 selects a random 0..3 idle gap after each pixel.
  task automatic send(input bit use_sof, input int npix, input int gap, input bit rnd);
    int g;
    for (int i = 0; i < npix; i++) begin
      step(0, 1, use_sof && (i == 0), rnd ? 9'($urandom) : 9'(i));
      g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
      if (g > 0) idle(g);
    end
  endtask

  task automatic clear_obs();
    wv_cnt = 0; fd_cnt = 0; wins_q.delete();
  endtask

  initial begin
    logic [143:0] w;
    // Reset state.
    step(1, 0, 0, 0);
    step(1, 1, 1, 9'h1ff);
    chk("reset_feat", feature_out, '0);

    // Continuous frame, pixel = row*8+col.
    clear_obs();
    send(1, N, 0, 0);
    idle(5);
    chk("f1_windows", 144'(wv_cnt), 144'(4));
    chk("f1_frame_done", 144'(fd_cnt), 144'(1));
    w = wins_q[0];
    chk("f1_w0_e0",  144'(w[0*9 +: 9]),  144'(0));
    chk("f1_w0_e3",  144'(w[3*9 +: 9]),  144'(3));
    chk("f1_w0_e12", 144'(w[12*9 +: 9]), 144'(24));
    chk("f1_w0_e15", 144'(w[15*9 +: 9]), 144'(27));
    w = wins_q[3];
    chk("f1_w3_e0",  144'(w[0*9 +: 9]),  144'(36));
    chk("f1_w3_e15", 144'(w[15*9 +: 9]), 144'(63));

    // Same frame with 3 idle cycles after every pixel.
    clear_obs();
    send(1, N, 3, 0);
    chk("gap_windows", 144'(wv_cnt), 144'(4));
    chk("gap_w3_e15", 144'(wins_q[3][15*9 +: 9]), 144'(63));

    // Frame A aborted by start-of-frame at its pixel 20, then a full frame B.
    clear_obs();
    send(1, 20, 0, 1);
    send(1, N, 0, 0);
    idle(5);
    chk("sof_windows", 144'(wv_cnt), 144'(4));
    chk("sof_frame_done", 144'(fd_cnt), 144'(1));

    // Reset after pixel 30, then a clean frame without in_sof.
    send(1, 31, 0, 0);
    step(1, 1, 0, 9'h55);
    chk("rst_feat", feature_out, '0);
    clear_obs();
    send(0, N, 0, 0);
    idle(5);
    chk("rst_windows", 144'(wv_cnt), 144'(4));
    chk("rst_w0_e15", 144'(wins_q[0][15*9 +: 9]), 144'(27));

    // Two back-to-back frames, no gap.
    clear_obs();
    send(1, N, 0, 0);
    send(0, N, 0, 0);
    idle(5);
    chk("b2b_windows", 144'(wv_cnt), 144'(8));
    chk("b2b_frame_done", 144'(fd_cnt), 144'(2));
    chk("b2b_f2_w0_e0", 144'(wins_q[4][0 +: 9]), 144'(0));

    // Randomized frames: random data and gaps, sometimes restarted by in_sof.
    for (int f = 0; f < 6; f++) begin
      clear_obs();
      if (($urandom % 3) == 0) send(1, int'($urandom_range(1, N - 1)), -1, 1);
      send(1, N, -1, 1);
      idle(5);
      chk("rnd_frame_done", 144'(fd_cnt), 144'(1));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
